// File: rtl/tff_mod_counter_pkg.sv
// Shared constants and the parameter legality check for the T-cell modulo counter.
package tff_mod_counter_pkg;

  localparam int unsigned DefaultWidth   = 4;
  localparam int unsigned DefaultModulus = 10;

  function automatic bit params_legal(int unsigned width, int unsigned modulus);
    return (width >= 1) && (width <= 16) && (modulus >= 2) && (modulus <= (32'd1 << width));
  endfunction

endpackage

// File: rtl/tff_mod_counter_if.sv
// Control/status bundle of the modulo counter; master drives the controls, slave is the counter.
interface tff_mod_counter_if import tff_mod_counter_pkg::*; #(
  parameter int unsigned WIDTH = DefaultWidth
);
  logic             En;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             Wrap;

  modport master (output En, Up, Load, D, input Q, TC, Wrap);
  modport slave  (input En, Up, Load, D, output Q, TC, Wrap);
endinterface

// File: rtl/tff_mod_counter_t_cell.sv
// T flip-flop with synchronous active-high reset; one per counter bit.
module t_cell (
  input  logic T,
  input  logic Reset,
  input  logic Clk,
  output logic Q,
  output logic Q_bar
);
  logic q_d, q_q;

  always_comb q_d = q_q ^ T;

  always_ff @(posedge Clk) begin
    if (Reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign Q     = q_q;
  assign Q_bar = ~q_q;
endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-MODULUS up/down counter: next count is turned into a toggle vector for per-bit T cells.
module tff_mod_counter import tff_mod_counter_pkg::*; #(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned MODULUS = DefaultModulus
) (
  input  logic           Clk,
  input  logic           Reset,
  tff_mod_counter_if.slave bus
);
  if (!params_legal(WIDTH, MODULUS)) begin : g_bad_params
    $fatal(1, "tff_mod_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q, q_bar, q_n, d_sat, t_vec;
  logic             at_max, at_zero, in_range, tc;
  logic             wrap_d, wrap_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_cell u_cell (
      .T    (t_vec[i]),
      .Reset(Reset),
      .Clk  (Clk),
      .Q    (q[i]),
      .Q_bar(q_bar[i])
    );
  end

  always_comb begin
    at_zero  = &q_bar;
    at_max   = (q == MaxVal);
    in_range = (32'(q) < MODULUS);
    d_sat    = (32'(bus.D) < MODULUS) ? bus.D : MaxVal;
    tc       = bus.En & (bus.Up ? at_max : at_zero);
  end

  // Reset lives in the cells, so only load/count/hold are resolved here.
  always_comb begin
    q_n = q;
    if (bus.Load) begin
      q_n = d_sat;
    end else if (bus.En) begin
      if (!in_range)   q_n = '0;
      else if (bus.Up) q_n = at_max ? '0 : q + 1'b1;
      else             q_n = at_zero ? MaxVal : q - 1'b1;
    end
    t_vec  = q_n ^ q;
    wrap_d = tc & ~bus.Load;
  end

  always_ff @(posedge Clk) begin
    if (Reset) wrap_q <= 1'b0;
    else       wrap_q <= wrap_d;
  end

  assign bus.Q    = q;
  assign bus.TC   = tc;
  assign bus.Wrap = wrap_q;
endmodule
